// File: rtl/screen_console_ctrl.sv
// Text-console write controller for the character screen RAM: turns PUTC/GOTO/CLEAR
// commands into registered byte writes at {row, col}, with line wrap, line clear and full clear.

module screen_console_ctrl_chk #(
    parameter int COLS = 80,
    parameter int ROWS = 40
) (
    input logic        clk,
    input logic        rst_n,
    input logic        cmd_ready,
    input logic        disp_en,
    input logic        wr_en,
    input logic [14:0] wr_addr,
    input logic [7:0]  cursor_x,
    input logic [6:0]  cursor_y
);
    localparam logic [7:0] COL_LAST = 8'(COLS - 1);
    localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);

    a_wr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en |-> ((wr_addr[7:0] <= COL_LAST) && (wr_addr[14:8] <= ROW_LAST)));

    a_cursor_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (cursor_x <= COL_LAST) && (cursor_y <= ROW_LAST));

    a_blank_only_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !disp_en |-> !cmd_ready);
endmodule

module screen_console_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    input  logic [7:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  cursor_x,
    output logic [6:0]  cursor_y,
    output logic        disp_en
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLR_LINE = 2'd1,
        ST_CLR_ALL  = 2'd2
    } state_t;

    localparam logic [1:0] OP_PUTC  = 2'd0;
    localparam logic [1:0] OP_GOTO  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] COL_LAST = 8'(COLS - 1);
    localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);

    state_t      state_r,    state_s;
    logic        wr_en_r,    wr_en_s;
    logic [14:0] wr_addr_r,  wr_addr_s;
    logic [7:0]  wr_data_r,  wr_data_s;
    logic [7:0]  cursor_x_r, cursor_x_s;
    logic [6:0]  cursor_y_r, cursor_y_s;
    logic        disp_en_r,  disp_en_s;
    logic [7:0]  clr_x_r,    clr_x_s;
    logic [6:0]  clr_y_r,    clr_y_s;

    // Wrap-around replaces scrolling: the row after the last one is row 0.
    function automatic logic [6:0] next_row(input logic [6:0] row);
        return (row == ROW_LAST) ? 7'd0 : row + 7'd1;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 15'd0;
            wr_data_r  <= 8'd0;
            cursor_x_r <= 8'd0;
            cursor_y_r <= 7'd0;
            disp_en_r  <= 1'b1;
            clr_x_r    <= 8'd0;
            clr_y_r    <= 7'd0;
        end else begin
            state_r    <= state_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            cursor_x_r <= cursor_x_s;
            cursor_y_r <= cursor_y_s;
            disp_en_r  <= disp_en_s;
            clr_x_r    <= clr_x_s;
            clr_y_r    <= clr_y_s;
        end
    end

    // Command decode and clear sequencing; commands are only taken while idle.
    always_comb begin
        state_s    = state_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = wr_addr_r;
        wr_data_s  = wr_data_r;
        cursor_x_s = cursor_x_r;
        cursor_y_s = cursor_y_r;
        disp_en_s  = disp_en_r;
        clr_x_s    = clr_x_r;
        clr_y_s    = clr_y_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUTC: begin
                            case (cmd_data)
                                CH_BS: begin
                                    if (cursor_x_r != 8'd0) begin
                                        cursor_x_s = cursor_x_r - 8'd1;
                                        wr_en_s    = 1'b1;
                                        wr_addr_s  = {cursor_y_r, cursor_x_r - 8'd1};
                                        wr_data_s  = 8'h00;
                                    end else begin
                                        cursor_x_s = cursor_x_r;
                                    end
                                end
                                CH_LF: begin
                                    cursor_x_s = 8'd0;
                                    cursor_y_s = next_row(cursor_y_r);
                                    clr_x_s    = 8'd0;
                                    state_s    = ST_CLR_LINE;
                                end
                                CH_CR: begin
                                    cursor_x_s = 8'd0;
                                end
                                default: begin
                                    wr_en_s   = 1'b1;
                                    wr_addr_s = {cursor_y_r, cursor_x_r};
                                    wr_data_s = cmd_data;
                                    if (cursor_x_r < COL_LAST) begin
                                        cursor_x_s = cursor_x_r + 8'd1;
                                    end else begin
                                        cursor_x_s = 8'd0;
                                        cursor_y_s = next_row(cursor_y_r);
                                        clr_x_s    = 8'd0;
                                        state_s    = ST_CLR_LINE;
                                    end
                                end
                            endcase
                        end
                        OP_GOTO: begin
                            cursor_x_s = (cmd_x > COL_LAST) ? COL_LAST : cmd_x;
                            cursor_y_s = (cmd_y > ROW_LAST) ? ROW_LAST : cmd_y;
                        end
                        OP_CLEAR: begin
                            cursor_x_s = 8'd0;
                            cursor_y_s = 7'd0;
                            disp_en_s  = 1'b0;
                            clr_x_s    = 8'd0;
                            clr_y_s    = 7'd0;
                            state_s    = ST_CLR_ALL;
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLR_LINE: begin
                wr_en_s   = 1'b1;
                wr_addr_s = {cursor_y_r, clr_x_r};
                wr_data_s = 8'h00;
                if (clr_x_r == COL_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    clr_x_s = clr_x_r + 8'd1;
                end
            end
            ST_CLR_ALL: begin
                wr_en_s   = 1'b1;
                wr_addr_s = {clr_y_r, clr_x_r};
                wr_data_s = 8'h00;
                if (clr_x_r == COL_LAST) begin
                    clr_x_s = 8'd0;
                    if (clr_y_r == ROW_LAST) begin
                        disp_en_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        clr_y_s = clr_y_r + 7'd1;
                    end
                end else begin
                    clr_x_s = clr_x_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign cursor_x  = cursor_x_r;
    assign cursor_y  = cursor_y_r;
    assign disp_en   = disp_en_r;

    screen_console_ctrl_chk #(.COLS(COLS), .ROWS(ROWS)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_ready (cmd_ready),
        .disp_en   (disp_en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );
endmodule

// File: tb/tb_screen_console_ctrl.sv
// Bench for screen_console_ctrl: directed scenarios plus random commands, all checked
// against a cursor/write-list model of the console rules.

module tb_screen_console_ctrl;
    localparam int COLS = 80;
    localparam int ROWS = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic        disp_en;

    int vec = 0;
    int err = 0;
    logic [22:0] exp_q[$];
    logic [22:0] act_q[$];
    int busy_cnt = 0;
    int dlow_cnt = 0;
    int mcx = 0;
    int mcy = 0;

    always #5 clk = ~clk;

    screen_console_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .disp_en(disp_en)
    );

    // Capture writes and busy/blank cycles on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) act_q.push_back({wr_addr, wr_data});
            if (!cmd_ready) busy_cnt++;
            if (!disp_en) dlow_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic exp_w(input int r, input int c, input int d);
        exp_q.push_back({7'(r), 8'(c), 8'(d)});
    endtask

    task automatic line_adv(output int busy);
        mcy = (mcy == ROWS - 1) ? 0 : mcy + 1;
        for (int c = 0; c < COLS; c++) exp_w(mcy, c, 0);
        busy = COLS;
    endtask

    // Console rules: update the model cursor and list every byte the command must write.
    task automatic model_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] x,
                             input logic [6:0] y, output int busy, output int dlow);
        busy = 0;
        dlow = 0;
        case (op)
            2'd0: begin
                if (d == 8'h0D) mcx = 0;
                else if (d == 8'h0A) begin mcx = 0; line_adv(busy); end
                else if (d == 8'h08) begin
                    if (mcx > 0) begin mcx = mcx - 1; exp_w(mcy, mcx, 0); end
                end else begin
                    exp_w(mcy, mcx, int'(d));
                    if (mcx < COLS - 1) mcx = mcx + 1;
                    else begin mcx = 0; line_adv(busy); end
                end
            end
            2'd1: begin
                mcx = (int'(x) > COLS - 1) ? COLS - 1 : int'(x);
                mcy = (int'(y) > ROWS - 1) ? ROWS - 1 : int'(y);
            end
            2'd2: begin
                mcx = 0;
                mcy = 0;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) exp_w(r, c, 0);
                busy = ROWS * COLS;
                dlow = ROWS * COLS;
            end
            default: ;
        endcase
    endtask

    // Issue one command, wait for completion, check cursor, timing and every write.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] x,
                           input logic [6:0] y, input string tag);
        int busy_e, dlow_e, n;
        model_cmd(op, d, x, y, busy_e, dlow_e);
        busy_cnt = 0;
        dlow_cnt = 0;
        vec++;
        if (cmd_ready !== 1'b1) begin err++; $display("FAIL %s ready_before: got %b want 1", tag, cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_x = x; cmd_y = y;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        vec++;
        if ({cursor_y, cursor_x} !== {7'(mcy), 8'(mcx)}) begin
            err++; $display("FAIL %s cursor_at_accept: got (%0d,%0d) want (%0d,%0d)", tag, cursor_x, cursor_y, mcx, mcy);
        end
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!cmd_ready && n < 5000);
        vec++;
        if (!cmd_ready) begin err++; $display("FAIL %s timeout: ready=%b want 1", tag, cmd_ready); end
        vec++;
        if (busy_cnt !== busy_e) begin err++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, busy_e); end
        vec++;
        if (dlow_cnt !== dlow_e) begin err++; $display("FAIL %s disp_low_cycles: got %0d want %0d", tag, dlow_cnt, dlow_e); end
        vec++;
        if (disp_en !== 1'b1) begin err++; $display("FAIL %s disp_en_after: got %b want 1", tag, disp_en); end
        vec++;
        if (act_q.size() !== exp_q.size()) begin
            err++; $display("FAIL %s write_count: got %0d want %0d", tag, act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            vec++;
            if (act_q[i] !== exp_q[i]) begin
                err++; $display("FAIL %s write[%0d]: got addr %h data %h want addr %h data %h",
                                tag, i, act_q[i][22:8], act_q[i][7:0], exp_q[i][22:8], exp_q[i][7:0]);
                break;
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'd0; cmd_x = 8'd0; cmd_y = 7'd0;
        repeat (3) @(negedge clk);
        #1;
        vec++;
        if ({wr_en, wr_addr, wr_data} !== 24'd0) begin err++; $display("FAIL reset_wr: got en %b addr %h data %h want 0", wr_en, wr_addr, wr_data); end
        vec++;
        if ({cursor_y, cursor_x} !== 15'd0) begin err++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
        vec++;
        if ({disp_en, cmd_ready} !== 2'b11) begin err++; $display("FAIL reset_flags: got disp %b ready %b want 1 1", disp_en, cmd_ready); end
        rst_n = 1'b1;
        mcx = 0; mcy = 0;
        act_q.delete(); exp_q.delete();
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int b, dl, x1, y1;
        model_cmd(2'd0, 8'h41, 8'd0, 7'd0, b, dl);
        x1 = mcx; y1 = mcy;
        model_cmd(2'd0, 8'h42, 8'd0, 7'd0, b, dl);
        busy_cnt = 0;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'h41;
        @(posedge clk); #1;
        vec++;
        if ({cmd_ready, cursor_y, cursor_x} !== {1'b1, 7'(y1), 8'(x1)}) begin
            err++; $display("FAIL b2b_first: got ready %b cursor (%0d,%0d) want 1 (%0d,%0d)", cmd_ready, cursor_x, cursor_y, x1, y1);
        end
        cmd_data = 8'h42;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk); #1;
        vec++;
        if ({cursor_y, cursor_x} !== {7'd0, 8'd2}) begin err++; $display("FAIL b2b_cursor: got (%0d,%0d) want (2,0)", cursor_x, cursor_y); end
        vec++;
        if (busy_cnt !== 0) begin err++; $display("FAIL b2b_ready_drop: got %0d busy cycles want 0", busy_cnt); end
        vec++;
        if (act_q.size() !== 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
            err++; $display("FAIL b2b_writes: got %0d writes first %h want 2 writes %h %h", act_q.size(),
                            (act_q.size() > 0) ? act_q[0] : 23'd0, exp_q[0], exp_q[1]);
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_directed();
        run_cmd(2'd1, 8'd0, 8'd79, 7'd5, "goto_79_5");
        run_cmd(2'd0, 8'h5A, 8'd0, 7'd0, "putc_wrap");
        vec++;
        if ({cursor_y, cursor_x} !== {7'd6, 8'd0}) begin err++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,6)", cursor_x, cursor_y); end
        run_cmd(2'd1, 8'd0, 8'd10, 7'd39, "goto_10_39");
        run_cmd(2'd0, 8'h0A, 8'd0, 7'd0, "lf_row_wrap");
        run_cmd(2'd1, 8'd0, 8'd200, 7'd100, "goto_clamp");
        vec++;
        if ({cursor_y, cursor_x} !== {7'd39, 8'd79}) begin err++; $display("FAIL clamp_cursor: got (%0d,%0d) want (79,39)", cursor_x, cursor_y); end
        run_cmd(2'd0, 8'h08, 8'd0, 7'd0, "bs_write");
        run_cmd(2'd0, 8'h0D, 8'd0, 7'd0, "cr");
        run_cmd(2'd3, 8'h55, 8'd3, 7'd3, "reserved");
        run_cmd(2'd1, 8'd0, 8'd0, 7'd0, "goto_0_0");
        run_cmd(2'd0, 8'h08, 8'd0, 7'd0, "bs_col0");
    endtask

    task automatic test_clear_queued();
        int b, dl, n;
        model_cmd(2'd2, 8'd0, 8'd0, 7'd0, b, dl);
        model_cmd(2'd0, 8'h31, 8'd0, 7'd0, b, dl);
        busy_cnt = 0; dlow_cnt = 0;
        cmd_valid = 1'b1; cmd_op = 2'd2;
        @(posedge clk); #1;
        vec++;
        if ({disp_en, cmd_ready, cursor_y, cursor_x} !== 17'd0) begin
            err++; $display("FAIL clear_accept: got disp %b ready %b cursor (%0d,%0d) want 0 0 (0,0)", disp_en, cmd_ready, cursor_x, cursor_y);
        end
        cmd_op = 2'd0; cmd_data = 8'h31;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!cmd_ready && n < 5000);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk); #1;
        vec++;
        if (busy_cnt !== ROWS * COLS) begin err++; $display("FAIL clear_busy: got %0d want %0d", busy_cnt, ROWS * COLS); end
        vec++;
        if (dlow_cnt !== ROWS * COLS) begin err++; $display("FAIL clear_disp_low: got %0d want %0d", dlow_cnt, ROWS * COLS); end
        vec++;
        if (act_q.size() !== ROWS * COLS + 1) begin err++; $display("FAIL clear_count: got %0d want %0d", act_q.size(), ROWS * COLS + 1); end
        vec++;
        if (act_q.size() > ROWS * COLS && act_q[ROWS * COLS - 1][22:8] !== 15'h274F) begin
            err++; $display("FAIL clear_last_addr: got %h want 274f", act_q[ROWS * COLS - 1][22:8]);
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            vec++;
            if (act_q[i] !== exp_q[i]) begin
                err++; $display("FAIL clear_write[%0d]: got %h want %h", i, act_q[i], exp_q[i]);
                break;
            end
        end
        vec++;
        if ({cursor_y, cursor_x} !== {7'd0, 8'd1}) begin err++; $display("FAIL queued_cursor: got (%0d,%0d) want (1,0)", cursor_x, cursor_y); end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        act_q.delete();
        cmd_valid = 1'b1; cmd_op = 2'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (act_q.size() < 100 && n < 500) begin @(negedge clk); #1; n++; end
        vec++;
        if (act_q.size() !== 100 || wr_en !== 1'b1) begin err++; $display("FAIL midclr_reach: got %0d writes wr_en %b want 100 1", act_q.size(), wr_en); end
        rst_n = 1'b0;
        #1;
        vec++;
        if ({wr_en, disp_en, cmd_ready, cursor_y, cursor_x, wr_addr} !== {3'b011, 15'd0, 15'd0}) begin
            err++; $display("FAIL midclr_reset: got wr_en %b disp %b ready %b cursor (%0d,%0d) addr %h want 0 1 1 (0,0) 0",
                            wr_en, disp_en, cmd_ready, cursor_x, cursor_y, wr_addr);
        end
        act_q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        mcx = 0; mcy = 0;
        repeat (30) @(negedge clk);
        #1;
        vec++;
        if (act_q.size() !== 0 || cmd_ready !== 1'b1 || disp_en !== 1'b1) begin
            err++; $display("FAIL midclr_resume: got %0d writes ready %b disp %b want 0 1 1", act_q.size(), cmd_ready, disp_en);
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int r, k;
        logic [1:0] op;
        logic [7:0] d, x;
        logic [6:0] y;
        for (int i = 0; i < 70; i++) begin
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 9);
            op = (r < 60) ? 2'd0 : (r < 94) ? 2'd1 : (r < 97) ? 2'd3 : 2'd2;
            d = (k == 0) ? 8'h08 : (k == 1) ? 8'h0A : (k == 2) ? 8'h0D : 8'($urandom_range(0, 255));
            x = (k < 4) ? 8'($urandom_range(74, 90)) : 8'($urandom_range(0, 255));
            y = 7'($urandom_range(0, 127));
            run_cmd(op, d, x, y, "random");
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_directed();
        test_clear_queued();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/screen_console_ctrl.md
# screen_console_ctrl

Text-console write controller for the VGA character screen buffer. It accepts character and cursor commands from the processor and sequences byte writes into the screen RAM write port at address {row[6:0], col[7:0]}. It also handles cursor advance, line wrap, per-line clearing on newline and full-screen clear. During a full clear it blanks the display through the screen RAM `selector` input.

## Interface
- `COLS`, 80, visible columns per row; 1..256
- `ROWS`, 40, visible rows; 1..40, so the highest address stays below 10240

- `clk`  in  1  system clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept; equals (state == IDLE)
- `cmd_op`  in  2  0=PUTC, 1=GOTO, 2=CLEAR, 3=reserved (accepted, no effect)
- `cmd_data`  in  8  character for PUTC
- `cmd_x`  in  8  target column for GOTO
- `cmd_y`  in  7  target row for GOTO
- `wr_en`  out  1  screen RAM write strobe, one cycle per byte
- `wr_addr`  out  15  {row, col}
- `wr_data`  out  8  byte to write
- `cursor_x`  out  8  current column
- `cursor_y`  out  7  current row
- `disp_en`  out  1  drives screen RAM `selector`; 0 during CLR_ALL

## Operation
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0
  - cursor_x=0, cursor_y=0
  - disp_en=1
  - state=IDLE, so cmd_ready=1
- A command is accepted on an edge where cmd_valid && cmd_ready.
- wr_en, wr_addr and wr_data are registered. wr_en is 0 in every cycle without a scheduled write.
- States: IDLE, CLR_LINE, CLR_ALL. The internal counter clr_x is 8 bits; clr_y is 7 bits.
- PUTC, printable (any byte except 0x08, 0x0A, 0x0D):
  - Write cmd_data at (cursor_x, cursor_y).
  - If cursor_x < COLS-1: cursor_x+1 and stay in IDLE.
  - Otherwise (auto-wrap): cursor_x=0, run a line advance.
- PUTC 0x0D: cursor_x=0, no write.
- PUTC 0x0A: cursor_x=0, run a line advance, no write.
- PUTC 0x08:
  - If cursor_x > 0: cursor_x-1 and write 0x00 at the new position.
  - If cursor_x = 0: no-op, no write.
- Line advance:
  - cursor_y = (cursor_y == ROWS-1) ? 0 : cursor_y+1. Wrap-around replaces scrolling.
  - Enter CLR_LINE with clr_x=0.
  - CLR_LINE writes 0x00 at (clr_x, new cursor_y) for clr_x = 0..COLS-1, one per cycle, then returns to IDLE.
- GOTO:
  - cursor_x = min(cmd_x, COLS-1); cursor_y = min(cmd_y, ROWS-1).
  - No write.
- CLEAR:
  - cursor set to (0,0); disp_en=0; enter CLR_ALL.
  - Writes 0x00 row-major to (clr_x, clr_y) for all ROWS×COLS cells, one per cycle.
  - On the last cell: disp_en=1, state returns to IDLE.
- Cursor outputs update on the accept edge, not after clearing finishes.
- Addresses are always {row, col} with col < COLS and row < ROWS. Columns COLS..255 of each row are never written.
- Reset asserted mid-operation: all outputs return to reset values immediately. The clear is aborted and is not resumed.

## Timing
- "After edge k" means the registered value visible in the cycle following rising edge k. Accept edge is E.
- Printable PUTC without wrap:
  - Write visible after E.
  - cmd_ready stays 1, so sustained throughput is 1 char/cycle.
- Printable PUTC at column COLS-1:
  - Char write after E.
  - Clear writes after E+1..E+COLS.
  - cmd_ready=0 after E..E+COLS-1 and returns to 1 after E+COLS.
- 0x0A: wr_en=0 after E; clear writes after E+1..E+COLS; cmd_ready returns to 1 after E+COLS.
- CLEAR:
  - Writes after E+1..E+ROWS·COLS.
  - disp_en=0 after E..E+ROWS·COLS-1.
  - disp_en and cmd_ready return to 1 after E+ROWS·COLS.
- 0x08, 0x0D, GOTO, reserved: single cycle; cmd_ready stays 1.
- cmd_valid held while cmd_ready=0: the command is held off and accepted on the first edge with cmd_ready=1. Nothing is dropped or duplicated.

## Test plan
- Reset, then PUTC 0x41, 0x42 on consecutive cycles -> writes (addr 0x0000, 0x41), then (0x0001, 0x42); cursor (2,0); cmd_ready never drops.
- GOTO (79,5), then PUTC 0x5A:
  - Write at addr 0x054F.
  - Clears addr 0x0600..0x064F over 80 cycles.
  - Cursor (0,6); cmd_ready low for exactly 80 cycles.
- GOTO (10,39), then PUTC 0x0A -> 80 zero writes at 0x0000..0x004F (row wrap to 0); cursor (0,0).
- GOTO (200,100) -> cursor (79,39). Then 0x08 -> write 0x00 at 0x274E, cursor (78,39). Then GOTO (0,0) and 0x08 -> no write.
- CLEAR:
  - 3200 writes of 0x00, the last at 0x274F.
  - disp_en low for exactly 3200 cycles; cmd_ready returns afterwards.
  - A queued PUTC 0x31 then writes at 0x0000.
- Assert rst_n low during CLEAR write #100 -> immediately wr_en=0, disp_en=1, cmd_ready=1, cursor (0,0). After release, no further clear writes.
